// File: rtl/fir_host_ctrl.sv
// fir_host_ctrl: loads samples into BRAM, launches the FIR, waits for done, then streams results out.
module fir_host_ctrl #(
  parameter logic [9:0]  INPUT_BASE     = 10'd0,
  parameter logic [9:0]  OUTPUT_BASE    = 10'd512,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_sel_pipelined,
  input  logic [9:0]  cmd_sample_count,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [9:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        fir_start,
  output logic        fir_sel_pipelined,
  output logic [9:0]  fir_input_addr,
  output logic [9:0]  fir_output_addr,
  output logic [9:0]  fir_sample_count,
  input  logic        fir_done,
  input  logic [31:0] fir_cycle_count,
  output logic        busy,
  output logic        err,
  output logic [31:0] last_cycles
);
  localparam logic [9:0] MAX_COUNT = OUTPUT_BASE - INPUT_BASE;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RADDR, RDATA} state_t;
  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d, cnt_q, cnt_d, addr_q;
  logic        sel_q, sel_d, cap_q, cap_d, err_q, err_d, rv_q, rv_d;
  logic [31:0] last_q, last_d, wcnt_q, wcnt_d;
  logic [7:0]  mdata_q, mdata_d;
  logic        bad;
  assign bad               = (cmd_sample_count == 10'd0) || (cmd_sample_count > MAX_COUNT);
  assign cmd_ready         = state_q == IDLE;
  assign s_ready           = state_q == LOAD;
  assign mem_we            = s_ready & s_valid;
  assign mem_wdata         = s_data;
  assign mem_addr          = mem_we ? INPUT_BASE + idx_q : (state_q == RADDR) ? OUTPUT_BASE + idx_q : addr_q;
  assign fir_start         = state_q == START;
  assign m_valid           = (state_q == RDATA) & rv_q;
  assign m_data            = mdata_q;
  assign busy              = state_q != IDLE;
  assign err               = err_q;
  assign last_cycles       = last_q;
  assign fir_sel_pipelined = sel_q;
  assign fir_sample_count  = cnt_q;
  assign fir_input_addr    = cap_q ? INPUT_BASE : 10'd0;
  assign fir_output_addr   = cap_q ? OUTPUT_BASE : 10'd0;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    cap_d   = cap_q;
    err_d   = err_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    mdata_d = mdata_q;
    rv_d    = rv_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        sel_d   = cmd_sel_pipelined;
        cnt_d   = cmd_sample_count;
        cap_d   = 1'b1;
        idx_d   = 10'd0;
        err_d   = bad;
        state_d = bad ? IDLE : LOAD;
      end
      LOAD: if (mem_we) begin
        idx_d   = (idx_q == cnt_q - 10'd1) ? 10'd0 : idx_q + 10'd1;
        state_d = (idx_q == cnt_q - 10'd1) ? START : LOAD;
      end
      START: begin
        wcnt_d  = 32'd0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q + 32'd1;
        if (wcnt_q >= 32'd2 && fir_done) begin
          last_d  = fir_cycle_count;
          idx_d   = 10'd0;
          state_d = RADDR;
        end else if (wcnt_q == TIMEOUT_CYCLES - 32'd1) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RADDR: begin
        rv_d    = 1'b0;
        state_d = RDATA;
      end
      RDATA: if (!rv_q) begin
        // first RDATA cycle: BRAM output is now valid, capture it before presenting
        mdata_d = mem_rdata;
        rv_d    = 1'b1;
      end else if (m_ready) begin
        rv_d    = 1'b0;
        idx_d   = (idx_q == cnt_q - 10'd1) ? 10'd0 : idx_q + 10'd1;
        state_d = (idx_q == cnt_q - 10'd1) ? IDLE : RADDR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 10'd0;
      cnt_q   <= 10'd0;
      sel_q   <= 1'b0;
      cap_q   <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 32'd0;
      wcnt_q  <= 32'd0;
      mdata_q <= 8'd0;
      rv_q    <= 1'b0;
      addr_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      mdata_q <= mdata_d;
      rv_q    <= rv_d;
      addr_q  <= mem_addr;
    end
  end
endmodule
